// File: rtl/pll_rst_seq_pkg.sv
// Shared types and default parameters for the PLL lock supervisor / staged reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int DEF_NCH       = 4;
  localparam int DEF_LOCK_FILT = 16;
  localparam int DEF_STAGE_DLY = 8;
  localparam int DEF_CNTW      = 16;

endpackage

// File: rtl/pll_rst_seq_cdc_sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module cdc_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL lock supervisor: debounces the synchronised lock flag, then releases NCH reset
// domains one every STAGE_DLY cycles, bit 0 first; lock loss or sw reset re-asserts all.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int LOCK_FILT = DEF_LOCK_FILT,
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int CNTW      = DEF_CNTW
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pll_locked,
  input  logic            i_sw_reset,
  output logic [NCH-1:0]  o_rst,
  output logic            o_ready,
  output logic [CNTW-1:0] o_loss_cnt,
  output logic [1:0]      o_state
);

  localparam int FW = $clog2(LOCK_FILT + 1);
  localparam int DW = $clog2(STAGE_DLY + 1);
  localparam int SW = $clog2(NCH + 1);

  localparam logic [FW-1:0] FILT_LAST  = FW'(LOCK_FILT - 1);
  localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DLY - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NCH - 1);

  typedef struct packed {
    state_e          state;
    logic [FW-1:0]   filt;
    logic [DW-1:0]   dly;
    logic [SW-1:0]   stage;
    logic [NCH-1:0]  rst;
    logic            ready;
    logic [CNTW-1:0] loss;
  } seq_t;

  seq_t r;
  seq_t nx;
  logic locked_s;

  cdc_sync2 u_lock_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     (i_pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    nx = r;
    case (r.state)
      WAIT_LOCK: begin
        if (locked_s) begin
          nx.state = FILTER;
          nx.filt  = '0;
        end
      end
      FILTER: begin
        // A drop during filtering is a failed lock attempt, not a loss event.
        if (!locked_s) begin
          nx.state = WAIT_LOCK;
        end else if (i_sw_reset) begin
          nx.filt = '0;
        end else if (r.filt == FILT_LAST) begin
          nx.state = RELEASE;
          nx.dly   = '0;
          nx.stage = '0;
        end else begin
          nx.filt = r.filt + FW'(1);
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          nx.state = WAIT_LOCK;
          nx.rst   = '1;
          nx.ready = 1'b0;
          if (r.loss != '1) nx.loss = r.loss + CNTW'(1);
        end else if (i_sw_reset) begin
          nx.state = FILTER;
          nx.filt  = '0;
          nx.rst   = '1;
          nx.ready = 1'b0;
        end else if (r.state == RELEASE) begin
          if (r.dly == DLY_LAST) begin
            nx.dly   = '0;
            nx.stage = r.stage + SW'(1);
            nx.rst   = r.rst & ~(NCH'(1) << r.stage);
            if (r.stage == STAGE_LAST) begin
              nx.state = RUN;
              nx.ready = 1'b1;
            end
          end else begin
            nx.dly = r.dly + DW'(1);
          end
        end
      end
      default: nx.state = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r       <= '0;
      r.state <= WAIT_LOCK;
      r.rst   <= '1;
    end else begin
      r <= nx;
    end
  end

  assign o_rst      = r.rst;
  assign o_ready    = r.ready;
  assign o_loss_cnt = r.loss;
  assign o_state    = r.state;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: default, CNTW=2 and minimal (NCH=1, LOCK_FILT=1, STAGE_DLY=1) instances.
module tb_pll_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut_a: defaults
  logic        a_reset = 1'b1, a_lk = 1'b0, a_sw = 1'b0;
  logic [3:0]  a_rst;
  logic        a_ready;
  logic [15:0] a_loss;
  logic [1:0]  a_state;
  // dut_b: CNTW=2
  logic        b_reset = 1'b1, b_lk = 1'b0, b_sw = 1'b0;
  logic [3:0]  b_rst;
  logic        b_ready;
  logic [1:0]  b_loss;
  logic [1:0]  b_state;
  // dut_c: NCH=1, LOCK_FILT=1, STAGE_DLY=1
  logic        c_reset = 1'b1, c_lk = 1'b0, c_sw = 1'b0;
  logic [0:0]  c_rst;
  logic        c_ready;
  logic [15:0] c_loss;
  logic [1:0]  c_state;

  pll_rst_seq dut_a (
    .i_clk(clk), .i_reset(a_reset), .i_pll_locked(a_lk), .i_sw_reset(a_sw),
    .o_rst(a_rst), .o_ready(a_ready), .o_loss_cnt(a_loss), .o_state(a_state)
  );

  pll_rst_seq #(.CNTW(2)) dut_b (
    .i_clk(clk), .i_reset(b_reset), .i_pll_locked(b_lk), .i_sw_reset(b_sw),
    .o_rst(b_rst), .o_ready(b_ready), .o_loss_cnt(b_loss), .o_state(b_state)
  );

  pll_rst_seq #(.NCH(1), .LOCK_FILT(1), .STAGE_DLY(1)) dut_c (
    .i_clk(clk), .i_reset(c_reset), .i_pll_locked(c_lk), .i_sw_reset(c_sw),
    .o_rst(c_rst), .o_ready(c_ready), .o_loss_cnt(c_loss), .o_state(c_state)
  );

  // Reference: "t" = cycles since the lock filter (re)started; outputs follow by arithmetic.
  typedef struct {
    bit active;
    int t;
    int cnt;
    bit s1;
    bit s2;
  } m_t;

  m_t ma, mb, mc;

  function automatic m_t m_step(m_t m, bit rst, bit lk, bit sw,
                                int lf, int sd, int nch, int cmax);
    m_t n;
    n = m;
    if (rst) begin
      n.active = 0; n.t = 0; n.cnt = 0; n.s1 = 0; n.s2 = 0;
      return n;
    end
    n.s1 = lk;
    n.s2 = m.s1;
    if (!m.active) begin
      if (m.s2) begin
        n.active = 1;
        n.t = 0;
      end
    end else if (!m.s2) begin
      n.active = 0;
      if (m.t >= lf && m.cnt < cmax) n.cnt = m.cnt + 1;
    end else if (sw) begin
      n.t = 0;
    end else if (m.t < lf + nch * sd) begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string nm, input m_t m, input int lf, input int sd,
                           input int nch, input logic [63:0] rst, input logic rdy,
                           input logic [1:0] st, input logic [63:0] loss);
    int rel;
    int es;
    logic [63:0] full;
    logic [63:0] er;
    rel = 0;
    if (m.active && m.t >= lf) rel = (m.t - lf) / sd;
    if (rel > nch) rel = nch;
    full = (64'd1 << nch) - 64'd1;
    er   = full & ~((64'd1 << rel) - 64'd1);
    if (!m.active)       es = 0;
    else if (m.t < lf)   es = 1;
    else if (rel == nch) es = 3;
    else                 es = 2;
    chk({nm, "_rst"}, rst, er);
    chk({nm, "_ready"}, 64'(rdy), 64'(m.active && rel == nch));
    chk({nm, "_state"}, 64'(st), 64'(es));
    chk({nm, "_loss"}, loss, 64'(m.cnt));
  endtask

  task automatic step();
    @(posedge clk);
    ma = m_step(ma, a_reset, a_lk, a_sw, 16, 8, 4, 65535);
    mb = m_step(mb, b_reset, b_lk, b_sw, 16, 8, 4, 3);
    mc = m_step(mc, c_reset, c_lk, c_sw, 1, 1, 1, 65535);
    @(negedge clk);
    cmp_model("mdl_a", ma, 16, 8, 4, 64'(a_rst), a_ready, a_state, 64'(a_loss));
    cmp_model("mdl_b", mb, 16, 8, 4, 64'(b_rst), b_ready, b_state, 64'(b_loss));
    cmp_model("mdl_c", mc, 1, 1, 1, 64'(c_rst), c_ready, c_state, 64'(c_loss));
  endtask

  function automatic bit next_lk(bit cur);
    if (cur) return ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
    return ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0;
  endfunction

  typedef struct {
    logic       rst;
    logic       lk;
    logic       sw;
    logic       e_rst;
    logic       e_ready;
    logic [1:0] e_state;
    int         e_loss;
  } vec_t;

  vec_t tbl[25];

  initial begin
    int n;
    int rel_edge[4];
    int loss_seq[5];
    logic [3:0] exp_rst;

    // minimal-config vectors: {reset, lock, sw, exp rst, exp ready, exp state, exp loss}
    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 1, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 2, 0};
    tbl[5]  = '{0, 1, 0, 0, 1, 3, 0};
    tbl[6]  = '{0, 1, 0, 0, 1, 3, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 3, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 3, 0};
    tbl[9]  = '{0, 0, 0, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 1, 0, 0, 1};
    tbl[12] = '{0, 1, 0, 1, 0, 1, 1};
    tbl[13] = '{0, 1, 0, 1, 0, 2, 1};
    tbl[14] = '{1, 1, 0, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 0, 1, 0, 0, 0};
    tbl[16] = '{0, 1, 0, 1, 0, 0, 0};
    tbl[17] = '{0, 1, 0, 1, 0, 1, 0};
    tbl[18] = '{0, 1, 1, 1, 0, 1, 0};
    tbl[19] = '{0, 1, 1, 1, 0, 1, 0};
    tbl[20] = '{0, 1, 0, 1, 0, 2, 0};
    tbl[21] = '{0, 1, 0, 0, 1, 3, 0};
    tbl[22] = '{0, 1, 1, 1, 0, 1, 0};
    tbl[23] = '{0, 1, 0, 1, 0, 2, 0};
    tbl[24] = '{0, 1, 0, 0, 1, 3, 0};

    ma = '{0, 0, 0, 0, 0};
    mb = ma;
    mc = ma;

    for (int i = 0; i < 4; i++) step();

    // minimal configuration, including reset during RELEASE
    for (int i = 0; i < 25; i++) begin
      c_reset = tbl[i].rst;
      c_lk    = tbl[i].lk;
      c_sw    = tbl[i].sw;
      step();
      chk($sformatf("tbl%0d_rst", i), 64'(c_rst), 64'(tbl[i].e_rst));
      chk($sformatf("tbl%0d_ready", i), 64'(c_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_state", i), 64'(c_state), 64'(tbl[i].e_state));
      chk($sformatf("tbl%0d_loss", i), 64'(c_loss), 64'(tbl[i].e_loss));
    end
    c_lk = 1'b0;

    // default release timeline
    chk("a_reset_rst", 64'(a_rst), 64'hF);
    chk("a_reset_loss", 64'(a_loss), 64'd0);
    rel_edge[0] = 27; rel_edge[1] = 35; rel_edge[2] = 43; rel_edge[3] = 51;
    a_reset = 1'b0;
    a_lk    = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      step();
      exp_rst = 4'hF;
      for (int k = 0; k < 4; k++) if (e >= rel_edge[k]) exp_rst[k] = 1'b0;
      chk($sformatf("t1_rst_e%0d", e), 64'(a_rst), 64'(exp_rst));
      chk($sformatf("t1_ready_e%0d", e), 64'(a_ready), 64'(e >= 51));
    end
    chk("t1_state_run", 64'(a_state), 64'd3);

    // lock loss in RUN, then mid-RELEASE
    a_lk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_run_loss_rst", 64'(a_rst), 64'hF);
    chk("t3_run_loss_ready", 64'(a_ready), 64'd0);
    chk("t3_run_loss_cnt", 64'(a_loss), 64'd1);
    a_lk = 1'b1;
    n = 0;
    while (a_rst != 4'b1100 && n < 100) begin step(); n++; end
    chk("t3_wait_rel1_timeout", 64'(a_rst == 4'b1100), 64'd1);
    a_lk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_rel_loss_rst", 64'(a_rst), 64'hF);
    chk("t3_rel_loss_state", 64'(a_state), 64'd0);
    chk("t3_rel_loss_cnt", 64'(a_loss), 64'd2);

    // lock flicker while filtering
    a_lk = 1'b1;
    n = 0;
    while (a_state != 2'd1 && n < 50) begin step(); n++; end
    chk("t2_wait_filter_timeout", 64'(a_state), 64'd1);
    for (int i = 0; i < 8; i++) step();
    a_lk = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t2_flicker_state", 64'(a_state), 64'd0);
    chk("t2_flicker_cnt", 64'(a_loss), 64'd2);
    a_lk = 1'b1;
    n = 0;
    while (a_state != 2'd1 && n < 50) begin step(); n++; end
    chk("t2_refilter_timeout", 64'(a_state), 64'd1);
    for (int i = 0; i < 23; i++) step();
    chk("t2_rst0_before", 64'(a_rst[0]), 64'd1);
    step();
    chk("t2_rst0_after", 64'(a_rst[0]), 64'd0);

    // software reset in RUN, then coincident with lock loss
    n = 0;
    while (!a_ready && n < 100) begin step(); n++; end
    chk("t5_wait_ready_timeout", 64'(a_ready), 64'd1);
    a_sw = 1'b1;
    step();
    a_sw = 1'b0;
    chk("t5_sw_rst", 64'(a_rst), 64'hF);
    chk("t5_sw_state", 64'(a_state), 64'd1);
    chk("t5_sw_cnt", 64'(a_loss), 64'd2);
    for (int i = 0; i < 47; i++) step();
    chk("t5_ready_early", 64'(a_ready), 64'd0);
    step();
    chk("t5_ready_on_time", 64'(a_ready), 64'd1);
    a_lk = 1'b0;
    step();
    step();
    a_sw = 1'b1;
    step();
    a_sw = 1'b0;
    chk("t5_both_state", 64'(a_state), 64'd0);
    chk("t5_both_cnt", 64'(a_loss), 64'd3);

    // saturating loss counter, CNTW=2
    loss_seq[0] = 1; loss_seq[1] = 2; loss_seq[2] = 3; loss_seq[3] = 3; loss_seq[4] = 3;
    b_reset = 1'b0;
    for (int l = 0; l < 5; l++) begin
      b_lk = 1'b1;
      n = 0;
      while (!b_ready && n < 200) begin step(); n++; end
      chk($sformatf("t4_wait_ready%0d_timeout", l), 64'(b_ready), 64'd1);
      b_lk = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk($sformatf("t4_loss%0d", l), 64'(b_loss), 64'(loss_seq[l]));
      chk($sformatf("t4_rst%0d", l), 64'(b_rst), 64'hF);
    end

    // randomized traffic on all three instances
    for (int i = 0; i < 3000; i++) begin
      a_lk = next_lk(a_lk);
      b_lk = next_lk(b_lk);
      c_lk = next_lk(c_lk);
      a_sw = ($urandom_range(0, 99) < 2);
      b_sw = ($urandom_range(0, 99) < 2);
      c_sw = ($urandom_range(0, 99) < 5);
      a_reset = ($urandom_range(0, 999) < 2);
      b_reset = ($urandom_range(0, 999) < 2);
      c_reset = ($urandom_range(0, 999) < 3);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Parametrised PLL lock supervisor and staged reset sequencer that sits directly after the system PLL wrapper.
- Synchronises and debounces the PLL lock flag, then releases NCH reset domains in a fixed order, one every STAGE_DLY cycles.
- Re-asserts all resets on lock loss or a software reset request, and counts lock-loss events for diagnostics.
- Replaces the bare `o_locked` fan-out with a deterministic, observable reset sequence.

Parameters:
- NCH, 4: number of reset outputs (domains); legal range 1..32.
- LOCK_FILT, 16: consecutive synchronised-locked cycles required before release; legal value >=1.
- STAGE_DLY, 8: cycles between successive domain releases, and before the first release; legal value >=1.
- CNTW, 16: width of the lock-loss event counter; legal value >=1.

Ports:
- i_clk  in  1  system clock, the only clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_pll_locked  in  1  PLL lock flag; asynchronous to i_clk.
- i_sw_reset  in  1  software reset request, level, synchronous to i_clk.
- o_rst  out  NCH  per-domain reset, active-high; bit 0 is released first.
- o_ready  out  1  all domains released, state RUN.
- o_loss_cnt  out  CNTW  saturating count of lock-loss events.
- o_state  out  2  current FSM state encoding, for debug.

Behaviour:
- Reset (i_reset=1 at an edge):
  - state=WAIT_LOCK; o_rst=all ones; o_ready=0; o_loss_cnt=0.
  - Synchroniser flops, filter counter, delay counter and stage index all =0.
  - Reset overrides every other input.
- Lock synchroniser: locked_s is a 2-flop copy of i_pll_locked (2-cycle latency). Only locked_s is used internally.
- State encoding: WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3. o_state is the registered state.
- WAIT_LOCK:
  - o_rst all ones.
  - locked_s=1 -> FILTER with filt_cnt=0.
  - i_sw_reset is ignored.
- FILTER:
  - locked_s=0 -> WAIT_LOCK. This is not counted as a loss.
  - i_sw_reset=1 -> filt_cnt=0 and stay in FILTER.
  - Otherwise filt_cnt++.
  - When filt_cnt==LOCK_FILT-1 -> RELEASE with dly=0, stage=0.
- RELEASE:
  - dly counts 0..STAGE_DLY-1.
  - When dly==STAGE_DLY-1: clear o_rst[stage] (registered, so visible after that edge), stage++, dly=0.
  - When the stage being released is NCH-1 -> RUN, and o_ready=1 on the same edge.
  - Already-released bits stay 0.
- RUN: o_ready=1, o_rst=all zeros. No counters are active.
- Lock loss (locked_s=0 while in RELEASE or RUN):
  - Next edge: o_rst=all ones, o_ready=0, state=WAIT_LOCK.
  - o_loss_cnt increments and saturates at 2^CNTW-1.
- Software reset (i_sw_reset=1 while in RELEASE or RUN, with locked_s=1):
  - Next edge: o_rst=all ones, o_ready=0, state=FILTER, filt_cnt=0.
  - o_loss_cnt is unchanged.
  - A held i_sw_reset keeps filt_cnt at 0, so release starts only after deassertion.
- Simultaneous lock loss and i_sw_reset: lock loss wins (WAIT_LOCK, count increments).
- Timing from i_pll_locked rising (stable, set up before edge 1):
  - locked_s=1 after edge 2; FILTER after edge 3.
  - o_rst[k] falls after edge 3+LOCK_FILT+(k+1)*STAGE_DLY.
  - o_ready rises with the o_rst[NCH-1] fall.
  - Defaults: o_rst[0] falls after edge 27, o_rst[3] and o_ready after edge 51.
- A glitch on i_pll_locked shorter than one cycle may be missed by the synchroniser. This is acceptable; the filter handles longer drops.
- Widths:
  - filt_cnt is $clog2(LOCK_FILT+1) bits.
  - dly is $clog2(STAGE_DLY+1) bits.
  - stage is $clog2(NCH+1) bits.
  - No wrap-around is possible within legal parameters.

Decomposition:
- Package pll_rst_seq_pkg holds:
  - the state typedef (2-bit enum) and the encoding constants above;
  - default parameter constants.
- Sub-module cdc_sync2: a 2-flop synchroniser with synchronous active-high reset to 0, instantiated for i_pll_locked.
- The FSM and counters are written as one registered state struct plus combinational next-state logic.

Test Plan:
1. Defaults; i_reset 4 cycles, then i_pll_locked=1 held -> o_rst=4'hF until edge 27. Bits clear one at a time at edges 27/35/43/51. o_ready=1 from edge 51; o_state=3.
2. Lock flicker in FILTER: locked_s low for 3 cycles at filt_cnt=10 -> o_state returns to 0, o_loss_cnt stays 0. The full LOCK_FILT is re-run and o_rst[0] falls 16+8 cycles after the FILTER re-entry.
3. Lock loss in RUN, then again mid-RELEASE (after o_rst[1] cleared) -> o_rst=4'hF next edge each time, o_ready=0, o_loss_cnt=1 then 2.
4. CNTW=2, five lock losses -> o_loss_cnt sequence 1,2,3,3,3.
5. i_sw_reset pulse (1 cycle) in RUN -> o_rst=4'hF, o_state=1, o_loss_cnt unchanged; re-release completes 16+32 cycles later. i_sw_reset and lock loss on the same cycle -> o_state=0, count increments.
6. NCH=1, LOCK_FILT=1, STAGE_DLY=1 -> o_rst[0] and o_ready change after edge 5. Also assert i_reset during RELEASE -> all outputs return to reset values at the next edge.
